// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port register-bank arbiter.
// Optional feature macro: MEM_ARB_INIT_EN (power-up zero-fill sweep of the bank).
package mem_arb_pkg;

    // Controller states; ST_INIT is only reachable when the init sweep is built in
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_INIT   = 2'd2
    } state_e;

    // Requester identifiers, also the encoding of the round-robin pointer
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of requester handshakes, read return path and bank command signals.
// The arbiter takes the slave view; requesters plus the bank take the master view.
// Optional feature macro: MEM_ARB_INIT_EN (only affects the meaning of busy).
interface mem_arb_if #(
    parameter int M = 8,
    parameter int N = 4
) ();

    logic         req0;
    logic         req1;
    logic         we0;
    logic         we1;
    logic [N-1:0] addr0;
    logic [N-1:0] addr1;
    logic [M-1:0] din0;
    logic [M-1:0] din1;
    logic         gnt0;
    logic         gnt1;
    logic         rvalid0;
    logic         rvalid1;
    logic [M-1:0] rdata;
    logic         busy;
    logic         mem_wrt;
    logic [N-1:0] mem_addr;
    logic [M-1:0] mem_din;
    logic [M-1:0] mem_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, din0, din1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy, mem_wrt, mem_addr, mem_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, din0, din1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy, mem_wrt, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that was
// not served last wins, otherwise the single eligible requester wins.
module rr_pick2 (
    input  logic [1:0] elig_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       valid_o
);

    // Tie-break against the most recently served requester
    always_comb begin
        gnt_o   = 2'b00;
        valid_o = |elig_i;
        if (elig_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = elig_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port register bank.
// All bank commands and requester outputs come straight from registers.
// Optional feature macro: MEM_ARB_INIT_EN adds an INIT state that zero-fills
// the bank after reset while holding busy high.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    mem_arb_if.slave bus
);

    state_e       state_q, state_d;
    logic         last_q, last_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [1:0]   rvalid_q, rvalid_d;
    logic [M-1:0] rdata_q, rdata_d;
    logic         wrt_q, wrt_d;
    logic [N-1:0] addr_q, addr_d;
    logic [M-1:0] din_q, din_d;
    logic [1:0]   elig;
    logic [1:0]   pick;
    logic         pick_valid;

`ifdef MEM_ARB_INIT_EN
    localparam logic [N:0] CNT_ONE = {{N{1'b0}}, 1'b1};
    logic [N:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
`endif

    // A requester granted at the last edge still shows its old req; ignore it
    assign elig = {bus.req1 & ~gnt_q[1], bus.req0 & ~gnt_q[0]};

    rr_pick2 u_pick (
        .elig_i  (elig),
        .last_i  (last_q),
        .gnt_o   (pick),
        .valid_o (pick_valid)
    );

    // Next-state logic: arbitration, command latching, read return and init sweep
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = 2'b00;
        rvalid_d = gnt_q & {2{~wrt_q}};
        rdata_d  = (|rvalid_d) ? bus.mem_dout : rdata_q;
        wrt_d    = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
`ifdef MEM_ARB_INIT_EN
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_ACCESS: begin
                if (pick_valid) begin
                    gnt_d   = pick;
                    state_d = ST_ACCESS;
                    if (pick[1]) begin
                        addr_d = bus.addr1;
                        wrt_d  = bus.we1;
                        din_d  = bus.din1;
                        last_d = REQ1;
                    end else begin
                        addr_d = bus.addr0;
                        wrt_d  = bus.we0;
                        din_d  = bus.din0;
                        last_d = REQ0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MEM_ARB_INIT_EN
            ST_INIT: begin
                if (cnt_q[N]) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                    wrt_d  = 1'b1;
                    addr_d = cnt_q[N-1:0];
                    din_d  = '0;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending access immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef MEM_ARB_INIT_EN
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`else
            state_q <= ST_IDLE;
`endif
            last_q   <= REQ1;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            wrt_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
`ifdef MEM_ARB_INIT_EN
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
`endif
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            wrt_q    <= wrt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign bus.gnt0     = gnt_q[0];
    assign bus.gnt1     = gnt_q[1];
    assign bus.rvalid0  = rvalid_q[0];
    assign bus.rvalid1  = rvalid_q[1];
    assign bus.rdata    = rdata_q;
    assign bus.mem_wrt  = wrt_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
`ifdef MEM_ARB_INIT_EN
    assign bus.busy     = busy_q;
`else
    assign bus.busy     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural register bank.
// Optional feature macro: MEM_ARB_INIT_EN (adds the power-up sweep checks).
module tb_mem_arbiter;

    localparam int M = 8;
    localparam int N = 4;

`ifdef MEM_ARB_INIT_EN
    localparam logic [M-1:0] ADDR8_AFTER_RESET = 8'h00;
`else
    localparam logic [M-1:0] ADDR8_AFTER_RESET = 8'h11;
`endif

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    logic [M-1:0] bank [2**N];

    mem_arb_if #(.M(M), .N(N)) bus ();

    mem_arbiter #(.M(M), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port bank: synchronous write, combinational read
    always @(posedge clk) begin
        if (bus.mem_wrt) bank[bus.mem_addr] <= bus.mem_din;
    end
    assign bus.mem_dout = bank[bus.mem_addr];

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive both requesters' request fields at once
    task automatic applyStimulus(input logic r0, input logic w0, input logic [N-1:0] a0,
                                 input logic [M-1:0] d0, input logic r1, input logic w1,
                                 input logic [N-1:0] a1, input logic [M-1:0] d1);
        bus.req0  = r0;
        bus.we0   = w0;
        bus.addr0 = a0;
        bus.din0  = d0;
        bus.req1  = r1;
        bus.we1   = w1;
        bus.addr1 = a1;
        bus.din1  = d1;
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an init sweep to finish, if one is running
    task automatic waitNotBusy();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            step();
            n++;
        end
        checkOutput("busy_bound", {31'd0, bus.busy}, 32'd0);
    endtask

    // Linear directed sequence of all scenarios
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        #12;
        checkOutput("rst_gnt",     {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        checkOutput("rst_rvalid",  {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        checkOutput("rst_wrt",     {31'd0, bus.mem_wrt}, 32'd0);
        checkOutput("rst_busy",    {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_rdata",   {24'd0, bus.rdata}, 32'd0);
        checkOutput("rst_addr",    {28'd0, bus.mem_addr}, 32'd0);
        checkOutput("rst_din",     {24'd0, bus.mem_din}, 32'd0);

`ifdef MEM_ARB_INIT_EN
        // Release reset with a read of address 5 already pending
        begin
            int busyCycles;
            applyStimulus(1'b1, 1'b0, 4'd5, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
            rst_n = 1'b1;
            busyCycles = 0;
            step();
            while (bus.busy && busyCycles < 40) begin
                checkOutput("init_wrt",  {31'd0, bus.mem_wrt}, 32'd1);
                checkOutput("init_addr", {28'd0, bus.mem_addr}, busyCycles);
                checkOutput("init_din",  {24'd0, bus.mem_din}, 32'd0);
                checkOutput("init_nogn", {31'd0, bus.gnt0}, 32'd0);
                busyCycles++;
                step();
            end
            checkOutput("init_len",    busyCycles, 32'd16);
            checkOutput("init_gnt_lo", {31'd0, bus.gnt0}, 32'd0);
            step();
            checkOutput("init_gnt0",   {31'd0, bus.gnt0}, 32'd1);
            applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
            step();
            checkOutput("init_rv0",    {31'd0, bus.rvalid0}, 32'd1);
            checkOutput("init_rdata",  {24'd0, bus.rdata}, 32'd0);
        end
`else
        rst_n = 1'b1;
        step();
        checkOutput("busy_tied", {31'd0, bus.busy}, 32'd0);
`endif

        // Uncontended write of 127 to address 7, then read it back
        applyStimulus(1'b1, 1'b1, 4'd7, 8'd127, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        checkOutput("wr_gnt0",  {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        checkOutput("wr_wrt",   {31'd0, bus.mem_wrt}, 32'd1);
        checkOutput("wr_addr",  {28'd0, bus.mem_addr}, 32'd7);
        checkOutput("wr_din",   {24'd0, bus.mem_din}, 32'd127);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        checkOutput("wr_gnt_lo", {31'd0, bus.gnt0}, 32'd0);
        checkOutput("wr_wrt_lo", {31'd0, bus.mem_wrt}, 32'd0);
        checkOutput("wr_no_rv",  {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        checkOutput("wr_hold_a", {28'd0, bus.mem_addr}, 32'd7);
        applyStimulus(1'b1, 1'b0, 4'd7, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        checkOutput("rd_gnt0",  {31'd0, bus.gnt0}, 32'd1);
        checkOutput("rd_wrt",   {31'd0, bus.mem_wrt}, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        checkOutput("rd_rv0",   {30'd0, bus.rvalid1, bus.rvalid0}, 32'd1);
        checkOutput("rd_data",  {24'd0, bus.rdata}, 32'd127);
        step();
        checkOutput("rd_rv_lo", {31'd0, bus.rvalid0}, 32'd0);
        checkOutput("rd_hold",  {24'd0, bus.rdata}, 32'd127);

        // Preload 255 at address 8 through requester 1
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd8, 8'd255);
        step();
        checkOutput("pre_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        step();

        // Simultaneous reads: requester 0 wins the tie, then requester 1
        applyStimulus(1'b1, 1'b0, 4'd7, 8'd0, 1'b1, 1'b0, 4'd8, 8'd0);
        step();
        checkOutput("tie_first",  {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        checkOutput("tie_addr0",  {28'd0, bus.mem_addr}, 32'd7);
        bus.req0 = 1'b0;
        step();
        checkOutput("tie_second", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        checkOutput("tie_rv0",    {30'd0, bus.rvalid1, bus.rvalid0}, 32'd1);
        checkOutput("tie_rd0",    {24'd0, bus.rdata}, 32'd127);
        bus.req1 = 1'b0;
        step();
        checkOutput("tie_rv1",    {30'd0, bus.rvalid1, bus.rvalid0}, 32'd2);
        checkOutput("tie_rd1",    {24'd0, bus.rdata}, 32'd255);
        step();

        // Both requesters hammering: grants alternate 0,1,0,1,0,1
        applyStimulus(1'b1, 1'b0, 4'd1, 8'd0, 1'b1, 1'b0, 4'd2, 8'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput($sformatf("alt_%0d", i), {30'd0, bus.gnt1, bus.gnt0},
                        (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        step();

        // Write 0x5A to 3 followed by an immediate read of 3 on the next grant
        applyStimulus(1'b1, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        checkOutput("wtr_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd3, 8'd0);
        step();
        checkOutput("wtr_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        bus.req1 = 1'b0;
        step();
        checkOutput("wtr_rv1",  {31'd0, bus.rvalid1}, 32'd1);
        checkOutput("wtr_data", {24'd0, bus.rdata}, 32'h5A);
        step();

        // Put a known 0x11 at address 8 before the aborted write
        applyStimulus(1'b1, 1'b1, 4'd8, 8'h11, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        bus.req0 = 1'b0;
        step();

        // Reset asserted while a write of 255 to 8 is on the bank command
        applyStimulus(1'b1, 1'b1, 4'd8, 8'd255, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        checkOutput("abort_wrt_hi", {31'd0, bus.mem_wrt}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_wrt_lo", {31'd0, bus.mem_wrt}, 32'd0);
        checkOutput("abort_gnt",    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        checkOutput("abort_rv",     {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        #10;
        rst_n = 1'b1;
        step();
        waitNotBusy();
        applyStimulus(1'b1, 1'b0, 4'd8, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        step();
        checkOutput("post_gnt0", {31'd0, bus.gnt0}, 32'd1);
        bus.req0 = 1'b0;
        step();
        checkOutput("post_rv0",   {31'd0, bus.rvalid0}, 32'd1);
        checkOutput("post_data",  {24'd0, bus.rdata}, {24'd0, ADDR8_AFTER_RESET});
        checkOutput("post_not255", {31'd0, (bus.rdata !== 8'd255)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
